// File: rtl/fpu_mm_master.sv
// Avalon-MM master that sequences one FPU operation: writes the operands and a start
// pulse, polls the done flag, reads the result and returns it on a ready/valid response.
module fpu_mm_master #(
    parameter int unsigned POLL_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_sign_a,
    input  logic        cmd_sign_b,
    input  logic [7:0]  cmd_int_a,
    input  logic [7:0]  cmd_frac_a,
    input  logic [7:0]  cmd_int_b,
    input  logic [7:0]  cmd_frac_b,
    input  logic [1:0]  cmd_opcode,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [4:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [2:0] {StIdle, StWrite, StPoll, StReadRes, StResp} state_e;

    localparam logic [15:0] PollLast = 16'(POLL_LIMIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  widx_q, widx_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [7:0]  int_a_q, int_a_d, frac_a_q, frac_a_d;
    logic [7:0]  int_b_q, int_b_d, frac_b_q, frac_b_d;
    logic [1:0]  opcode_q, opcode_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            widx_q        <= 4'd0;
            poll_cnt_q    <= 16'd0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            int_a_q       <= 8'd0;
            frac_a_q      <= 8'd0;
            int_b_q       <= 8'd0;
            frac_b_q      <= 8'd0;
            opcode_q      <= 2'd0;
            rsp_result_q  <= 32'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            poll_cnt_q    <= poll_cnt_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            int_a_q       <= int_a_d;
            frac_a_q      <= frac_a_d;
            int_b_q       <= int_b_d;
            frac_b_q      <= frac_b_d;
            opcode_q      <= opcode_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        poll_cnt_d    = poll_cnt_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        int_a_d       = int_a_q;
        frac_a_d      = frac_a_q;
        int_b_d       = int_b_q;
        frac_b_d      = frac_b_q;
        opcode_d      = opcode_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_address   = 5'd0;
        avm_writedata = 32'd0;

        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    sign_a_d = cmd_sign_a;
                    sign_b_d = cmd_sign_b;
                    int_a_d  = cmd_int_a;
                    frac_a_d = cmd_frac_a;
                    int_b_d  = cmd_int_b;
                    frac_b_d = cmd_frac_b;
                    opcode_d = cmd_opcode;
                    widx_d   = 4'd0;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                avm_write = 1'b1;
                // Index 7 raises the start bit, index 8 clears it again at the same address.
                avm_address = (widx_q < 4'd8) ? {1'b0, widx_q} : 5'd7;
                case (widx_q)
                    4'd0:    avm_writedata = {31'd0, sign_a_q};
                    4'd1:    avm_writedata = {24'd0, int_a_q};
                    4'd2:    avm_writedata = {24'd0, frac_a_q};
                    4'd3:    avm_writedata = {31'd0, sign_b_q};
                    4'd4:    avm_writedata = {24'd0, int_b_q};
                    4'd5:    avm_writedata = {24'd0, frac_b_q};
                    4'd6:    avm_writedata = {30'd0, opcode_q};
                    4'd7:    avm_writedata = 32'd1;
                    default: avm_writedata = 32'd0;
                endcase
                if (!avm_waitrequest) begin
                    if (widx_q == 4'd8) begin
                        poll_cnt_d = 16'd0;
                        state_d    = StPoll;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            StPoll: begin
                avm_read    = 1'b1;
                avm_address = 5'd9;
                if (!avm_waitrequest) begin
                    if (avm_readdata[0]) begin
                        state_d = StReadRes;
                    end else if (poll_cnt_q == PollLast) begin
                        rsp_result_d  = 32'd0;
                        rsp_timeout_d = 1'b1;
                        state_d       = StResp;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end
            end
            StReadRes: begin
                avm_read    = 1'b1;
                avm_address = 5'd8;
                if (!avm_waitrequest) begin
                    rsp_result_d  = avm_readdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign avm_chipselect = avm_write | avm_read;
    assign busy           = (state_q != StIdle);
    assign rsp_result     = rsp_result_q;
    assign rsp_timeout    = rsp_timeout_q;

endmodule

// File: tb/tb_fpu_mm_master.sv
// Bench for fpu_mm_master: stalling Avalon slave model with a transfer log, table and
// random transactions checked against expectations derived from the operation rules.
module tb_fpu_mm_master;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_sign_a = 1'b0, cmd_sign_b = 1'b0;
    logic [7:0]  cmd_int_a = 8'd0, cmd_frac_a = 8'd0, cmd_int_b = 8'd0, cmd_frac_b = 8'd0;
    logic [1:0]  cmd_opcode = 2'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic        busy;
    logic [4:0]  avm_address;
    logic        avm_chipselect, avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    always #5 clk = ~clk;

    fpu_mm_master #(.POLL_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_sign_a      (cmd_sign_a),
        .cmd_sign_b      (cmd_sign_b),
        .cmd_int_a       (cmd_int_a),
        .cmd_frac_a      (cmd_frac_a),
        .cmd_int_b       (cmd_int_b),
        .cmd_frac_b      (cmd_frac_b),
        .cmd_opcode      (cmd_opcode),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_timeout     (rsp_timeout),
        .busy            (busy),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // ---------------- slave model ----------------
    int          cfg_stall = 0;
    int          cfg_done = 0;
    logic [31:0] cfg_res = 32'd0;
    int          stall_cnt, poll_num;
    bit          prev_stall;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        p_w, p_r;
    int          stall_viol = 0, proto_viol = 0;
    int          lg_a[$];
    logic [31:0] lg_d[$];
    bit          lg_w[$];

    assign avm_waitrequest = (avm_write || avm_read) && (stall_cnt < cfg_stall);

    always_comb begin
        avm_readdata = 32'd0;
        if (avm_address == 5'd9)
            avm_readdata = (poll_num >= cfg_done) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
        else if (avm_address == 5'd8)
            avm_readdata = cfg_res;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt  <= 0;
            poll_num   <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (avm_address != p_addr || avm_writedata != p_data ||
                               avm_write != p_w || avm_read != p_r))
                stall_viol <= stall_viol + 1;
            if ((avm_chipselect != (avm_write | avm_read)) || (avm_write && avm_read) ||
                (busy == cmd_ready))
                proto_viol <= proto_viol + 1;
            prev_stall <= avm_waitrequest;
            p_addr <= avm_address;
            p_data <= avm_writedata;
            p_w    <= avm_write;
            p_r    <= avm_read;
            if ((avm_write || avm_read) && !avm_waitrequest) begin
                stall_cnt <= 0;
                lg_a.push_back(int'(avm_address));
                lg_d.push_back(avm_write ? avm_writedata : 32'd0);
                lg_w.push_back(avm_write);
                if (avm_read && avm_address == 5'd9) poll_num <= poll_num + 1;
                if (avm_write && avm_address == 5'd7 && avm_writedata == 32'd0) poll_num <= 0;
            end else if (avm_waitrequest) begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int passed = 0;

    task automatic check(input bit ok, input string name, input string det);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, det);
    endtask

    typedef struct {
        bit          sa;
        bit [7:0]    ia, fa;
        bit          sb;
        bit [7:0]    ib, fb;
        bit [1:0]    op;
        int          stall;
        int          done_after;
        logic [31:0] slave_res;
        int          rdy_delay;
        logic [31:0] exp_res;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    // Expected outcome from the operation rules: nine writes, polls until done or LIMIT
    // misses, one result read on success; every transfer costs stall+1 cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   ok = (v.done_after < int'(LIMIT));
        int   polls = ok ? v.done_after + 1 : int'(LIMIT);
        int   xfers = 9 + polls + (ok ? 1 : 0);
        r.exp_res = ok ? v.slave_res : 32'd0;
        r.exp_to  = !ok;
        r.exp_lat = xfers * (v.stall + 1) + 1;
        return r;
    endfunction

    task automatic drive_cmd(input vec_t v);
        cmd_sign_a = v.sa; cmd_int_a = v.ia; cmd_frac_a = v.fa;
        cmd_sign_b = v.sb; cmd_int_b = v.ib; cmd_frac_b = v.fb;
        cmd_opcode = v.op;
        cmd_valid  = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int          ea[$];
        logic [31:0] ed[$];
        bit          ew[$];
        bit          ok = (v.done_after < int'(LIMIT));
        int          polls = ok ? v.done_after + 1 : int'(LIMIT);
        int          base, sv0, pv0, n, lat, bad_at;
        logic [31:0] r0;
        logic        t0;
        bit          hold_bad;

        ea = '{0, 1, 2, 3, 4, 5, 6, 7, 7};
        ed = '{{31'd0, v.sa}, {24'd0, v.ia}, {24'd0, v.fa}, {31'd0, v.sb}, {24'd0, v.ib},
               {24'd0, v.fb}, {30'd0, v.op}, 32'd1, 32'd0};
        ew = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < polls; i++) begin
            ea.push_back(9); ed.push_back(32'd0); ew.push_back(1'b0);
        end
        if (ok) begin
            ea.push_back(8); ed.push_back(32'd0); ew.push_back(1'b0);
        end

        @(negedge clk);
        cfg_stall = v.stall; cfg_done = v.done_after; cfg_res = v.slave_res;
        base = lg_a.size(); sv0 = stall_viol; pv0 = proto_viol;
        drive_cmd(v);
        rsp_ready = (v.rdy_delay == 0);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check(cmd_ready == 1'b1, {tag, "_accept"}, $sformatf("cmd_ready=%0b want 1", cmd_ready));
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
        check(rsp_valid == 1'b1, {tag, "_rsp_seen"}, $sformatf("rsp_valid=%0b want 1", rsp_valid));
        check(lat == v.exp_lat, {tag, "_latency"}, $sformatf("got %0d want %0d", lat, v.exp_lat));
        check(rsp_result == v.exp_res, {tag, "_result"},
              $sformatf("got %h want %h", rsp_result, v.exp_res));
        check(rsp_timeout == v.exp_to, {tag, "_timeout"},
              $sformatf("got %0b want %0b", rsp_timeout, v.exp_to));
        r0 = rsp_result; t0 = rsp_timeout;
        if (v.rdy_delay > 0) begin
            hold_bad = 1'b0;
            for (int i = 0; i < v.rdy_delay; i++) begin
                @(negedge clk);
                cmd_valid = (i % 3 == 1);
                if (!rsp_valid || rsp_result != r0 || rsp_timeout != t0 || cmd_ready || !busy)
                    hold_bad = 1'b1;
            end
            check(!hold_bad, {tag, "_resp_hold"},
                  $sformatf("hold_bad=%0b want 0 (v=%0b r=%h)", hold_bad, rsp_valid, rsp_result));
            rsp_ready = 1'b1;
            cmd_valid = 1'b1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check(cmd_ready && !busy && !rsp_valid, {tag, "_back_idle"},
              $sformatf("ready=%0b busy=%0b valid=%0b want 1/0/0", cmd_ready, busy, rsp_valid));
        repeat (3) @(negedge clk);
        check(lg_a.size() - base == ea.size(), {tag, "_xfer_count"},
              $sformatf("got %0d want %0d", lg_a.size() - base, ea.size()));
        bad_at = -1;
        for (int i = 0; i < ea.size() && base + i < lg_a.size(); i++) begin
            if (bad_at < 0 && (lg_a[base+i] != ea[i] || lg_d[base+i] != ed[i] ||
                               lg_w[base+i] != ew[i]))
                bad_at = i;
        end
        check(bad_at < 0, {tag, "_bus_seq"}, (bad_at < 0) ? "" :
              $sformatf("xfer %0d got a=%0d d=%h w=%0b want a=%0d d=%h w=%0b", bad_at,
                        lg_a[base+bad_at], lg_d[base+bad_at], lg_w[base+bad_at],
                        ea[bad_at], ed[bad_at], ew[bad_at]));
        check(stall_viol == sv0 && proto_viol == pv0, {tag, "_protocol"},
              $sformatf("stall_viol=%0d proto_viol=%0d want 0/0", stall_viol - sv0, proto_viol - pv0));
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        // sa ia fa sb ib fb op stall done res rdy | exp_res exp_to exp_lat
        tbl[0] = '{0, 8'h03, 8'h80, 0, 8'h01, 8'h40, 2'd0, 0, 0, 32'h0004C000, 0,
                   32'h0004C000, 0, 12};
        tbl[1] = '{0, 8'h03, 8'h80, 0, 8'h01, 8'h40, 2'd0, 2, 0, 32'h0004C000, 0,
                   32'h0004C000, 0, 34};
        tbl[2] = '{1, 8'h7F, 8'h01, 0, 8'h02, 8'hFF, 2'd1, 0, 100, 32'h12345678, 0,
                   32'h0, 1, 14};
        tbl[3] = '{1, 8'hA5, 8'h5A, 1, 8'h3C, 8'hC3, 2'd3, 0, 2, 32'hDEADBEEF, 10,
                   32'hDEADBEEF, 0, 14};
        tbl[4] = '{0, 8'h10, 8'h20, 1, 8'h30, 8'h40, 2'd2, 1, 3, 32'h80000001, 0,
                   32'h80000001, 0, 29};
        tbl[5] = '{0, 8'hFF, 8'hFF, 1, 8'hFF, 8'hFF, 2'd3, 0, 4, 32'hCAFEF00D, 2,
                   32'h0, 1, 14};

        #1;
        check(cmd_ready && !rsp_valid && rsp_result == 0 && !rsp_timeout && !busy &&
              avm_address == 0 && !avm_chipselect && !avm_write && !avm_read &&
              avm_writedata == 0, "reset_state",
              $sformatf("ready=%0b valid=%0b res=%h to=%0b busy=%0b a=%0d cs=%0b w=%0b r=%0b",
                        cmd_ready, rsp_valid, rsp_result, rsp_timeout, busy, avm_address,
                        avm_chipselect, avm_write, avm_read));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 8; i++) begin
            rv.sa = 1'($urandom); rv.ia = 8'($urandom); rv.fa = 8'($urandom);
            rv.sb = 1'($urandom); rv.ib = 8'($urandom); rv.fb = 8'($urandom);
            rv.op = 2'($urandom);
            rv.stall = int'($urandom_range(0, 2));
            rv.done_after = int'($urandom_range(0, 5));
            rv.slave_res = $urandom;
            rv.rdy_delay = int'($urandom_range(0, 3));
            run_txn(model(rv), $sformatf("rnd%0d", i));
        end

        // Reset during the fifth write, then a clean restart.
        begin
            int  n;
            int  base;
            bit  act;
            @(negedge clk);
            cfg_stall = 0; cfg_done = 0; cfg_res = 32'h0004C000;
            drive_cmd(tbl[0]);
            rsp_ready = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            n = 0;
            while (!(avm_write && avm_address == 5'd4) && n < 30) begin @(negedge clk); n++; end
            check(avm_write && avm_address == 5'd4, "rst_fifth_write",
                  $sformatf("w=%0b a=%0d want 1/4", avm_write, avm_address));
            reset_n = 1'b0;
            #1;
            check(!avm_chipselect && !avm_write && !avm_read && avm_address == 0 &&
                  avm_writedata == 0 && cmd_ready && !busy && !rsp_valid, "rst_midtxn",
                  $sformatf("cs=%0b w=%0b r=%0b a=%0d d=%h ready=%0b busy=%0b",
                            avm_chipselect, avm_write, avm_read, avm_address, avm_writedata,
                            cmd_ready, busy));
            rsp_ready = 1'b0;
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            base = lg_a.size();
            act = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (avm_chipselect || busy) act = 1'b1;
            end
            check(!act && lg_a.size() == base, "rst_quiet",
                  $sformatf("activity=%0b xfers=%0d want 0/0", act, lg_a.size() - base));
            run_txn(tbl[0], "post_rst");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/fpu_mm_master.md
FPU_MM_MASTER -- requirements
Module: fpu_mm_master

Interface
REQ-001 Parameter: POLL_LIMIT, default 1023, maximum number of unsuccessful done-polls before a timeout is reported (range 1..65535).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  an operation request is present.
REQ-005 cmd_ready  output  1  the block accepts a request this cycle.
REQ-006 cmd_sign_a, cmd_sign_b  input  1 each  operand sign bits.
REQ-007 cmd_int_a, cmd_frac_a, cmd_int_b, cmd_frac_b  input  8 each  operand integer and fraction bytes.
REQ-008 cmd_opcode  input  2  FPU operation select.
REQ-009 rsp_valid  output  1  a result is presented.
REQ-010 rsp_ready  input  1  the consumer takes the result.
REQ-011 rsp_result  output  32  FPU result word.
REQ-012 rsp_timeout  output  1  the result is invalid because done never rose.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 avm_address  output  5  Avalon-MM word address to the FPU slave.
REQ-015 avm_chipselect, avm_write, avm_read  output  1 each  Avalon-MM controls.
REQ-016 avm_writedata  output  32; avm_readdata  input  32; avm_waitrequest  input  1  slave stall.

Function
REQ-017 States SHALL be IDLE, WRITE, POLL, READ_RES and RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready all command fields SHALL be latched and the state SHALL go to WRITE with the write index cleared to 0.
REQ-019 A bus transfer SHALL complete in a cycle where (avm_write||avm_read) && !avm_waitrequest; until then address, data and strobes SHALL be held stable.
REQ-020 avm_chipselect SHALL equal avm_write||avm_read; at most one of avm_write/avm_read SHALL be high.
REQ-021 WRITE SHALL issue nine writes in order: addr 0 sign_a, 1 int_a, 2 frac_a, 3 sign_b, 4 int_b, 5 frac_b, 6 opcode, 7 value 1, 7 value 0; writedata SHALL be zero-extended to 32 bits.
REQ-022 After the ninth write completes the state SHALL go to POLL with the poll counter cleared.
REQ-023 POLL SHALL read addr 9 continuously; on a completed read with readdata[0]=1 go to READ_RES; with readdata[0]=0 increment the counter.
REQ-024 When the counter reaches POLL_LIMIT unsuccessful polls the state SHALL go to RESP with rsp_result=0 and rsp_timeout=1.
REQ-025 READ_RES SHALL read addr 8, capture avm_readdata into rsp_result on completion, set rsp_timeout=0 and go to RESP.
REQ-026 avm_readdata SHALL be sampled in the same cycle as the completing read (zero read latency).
REQ-027 RESP SHALL hold rsp_valid=1 with stable rsp_result/rsp_timeout until rsp_ready=1, then return to IDLE; no bus activity in RESP or IDLE.
REQ-028 With waitrequest low, done on the first poll and rsp_ready held at 1, command accepted in cycle N SHALL give writes N+1..N+9, poll N+10, result read N+11, rsp_valid N+12, cmd_ready again N+13.
REQ-029 cmd_valid arriving while busy SHALL be ignored (held off by cmd_ready=0), never dropped or overwritten.

Reset
REQ-030 While reset_n=0, immediately and without clock: state IDLE; cmd_ready=1; rsp_valid=0, rsp_result=0, rsp_timeout=0, busy=0; all avm outputs 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it immediately, with no further bus transfer after reset_n rises until a new command is accepted.

Verification
REQ-032 Cmd a=+3.5 (0,0x03,0x80), b=+1.25 (0,0x01,0x40), op=0, slave model returns done=1 on first poll, result 0x0004C000 -> exact write sequence of REQ-021, rsp_valid at N+12, rsp_result=0x0004C000, rsp_timeout=0.
REQ-033 Slave asserts waitrequest 2 cycles on every transfer -> all signals held stable while stalled; same ordering and result; total 3x transfer cycles.
REQ-034 POLL_LIMIT=4, done never set -> exactly 4 reads of addr 9, then rsp_valid with rsp_result=0, rsp_timeout=1.
REQ-035 rsp_ready held 0 for 10 cycles in RESP, cmd_valid pulsed meanwhile -> rsp outputs stable, cmd_ready=0, second command accepted only after the response handshake.
REQ-036 reset_n dropped during the fifth write -> avm outputs 0 in the same cycle; after release, no bus activity until a new cmd_valid, which then restarts at addr 0.
